// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master side drives requests; the slave side (arbiter) returns the grant.
interface rr_onehot_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  modport master (output req, input gnt, input gnt_valid, input timeout);
  modport slave  (input req, output gnt, output gnt_valid, output timeout);
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Eight-way round-robin arbiter with a registered one-hot grant, a mandatory
// idle gap between grants and an optional maximum-hold timeout.
module rr_onehot_arbiter #(
  parameter int NREQ     = 8,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_onehot_arbiter_if.slave   bus
);

  if (NREQ != 8) begin : g_bad_nreq
    $error("rr_onehot_arbiter: NREQ must be 8");
  end
  if ((MAX_HOLD >> CNT_W) != 0) begin : g_bad_hold
    $error("rr_onehot_arbiter: MAX_HOLD must be below 2**CNT_W");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [CNT_W-1:0] HOLD_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             gnt_valid_q;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]       win_s;
  logic [2:0]       cand_s;
  logic             found_s;

  // State register; every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 3'd0;
      idx_q       <= 3'd0;
      gnt_q       <= 8'h00;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= |gnt_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Priority scan starting at ptr, plus next-state and grant logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    win_s      = ptr_q;
    cand_s     = 3'd0;
    found_s    = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cand_s = ptr_q + 3'(i);
      if (!found_s && bus.req[cand_s]) begin
        win_s   = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          gnt_d      = 8'h01 << win_s;
          idx_d      = win_s;
          hold_cnt_d = {CNT_W{1'b0}};
          state_d    = S_GRANT;
        end else begin
          gnt_d = 8'h00;
        end
      end
      S_GRANT: begin
        // A dropped request wins over a timeout landing on the same edge.
        if (!bus.req[idx_q]) begin
          gnt_d   = 8'h00;
          ptr_d   = idx_q + 3'd1;
          state_d = S_IDLE;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
          gnt_d     = 8'h00;
          ptr_d     = idx_q + 3'd1;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      default: begin
        gnt_d   = 8'h00;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scoreboard bench: directed steps queue hand-computed expectations, a monitor
// compares them after each rising edge. DUT a uses MAX_HOLD=4, DUT b MAX_HOLD=3.
module tb_rr_onehot_arbiter;

  typedef struct {
    bit         sel;
    logic [7:0] gnt;
    logic       to;
    int         tag;
  } exp_t;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_cmp;
  int   n_err;
  int   step_no;
  exp_t exp_q[$];
  exp_t mon_e;

  rr_onehot_arbiter_if bus_a ();
  rr_onehot_arbiter_if bus_b ();

  rr_onehot_arbiter #(.NREQ(8), .MAX_HOLD(4), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  rr_onehot_arbiter #(.NREQ(8), .MAX_HOLD(3), .CNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pop one expectation per rising edge and compare.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [7:0] ag;
      logic       av;
      logic       at;
      mon_e = exp_q.pop_front();
      ag = mon_e.sel ? bus_b.gnt       : bus_a.gnt;
      av = mon_e.sel ? bus_b.gnt_valid : bus_a.gnt_valid;
      at = mon_e.sel ? bus_b.timeout   : bus_a.timeout;
      n_cmp++;
      if (ag !== mon_e.gnt || av !== (|mon_e.gnt) || at !== mon_e.to) begin
        n_err++;
        $display("FAIL step%0d dut_%s: got gnt=%h valid=%b timeout=%b, want gnt=%h valid=%b timeout=%b",
                 mon_e.tag, mon_e.sel ? "b" : "a", ag, av, at, mon_e.gnt, |mon_e.gnt, mon_e.to);
      end
    end
  end

  // Drive req at the falling edge and queue the outputs expected after the next rising edge.
  task automatic step(input bit sel, input logic [7:0] r, input logic [7:0] g, input logic t);
    exp_t e;
    @(negedge clk);
    if (sel) bus_b.req = r;
    else     bus_a.req = r;
    step_no++;
    e.sel = sel;
    e.gnt = g;
    e.to  = t;
    e.tag = step_no;
    exp_q.push_back(e);
  endtask

  // Immediate check of DUT a outputs against the all-quiet reset values.
  task automatic chk_quiet_a(input string name);
    n_cmp++;
    if (bus_a.gnt !== 8'h00 || bus_a.gnt_valid !== 1'b0 || bus_a.timeout !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got gnt=%h valid=%b timeout=%b, want 00/0/0",
               name, bus_a.gnt, bus_a.gnt_valid, bus_a.timeout);
    end
  endtask

  task automatic reset_a();
    @(negedge clk);
    bus_a.req = 8'h00;
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    step_no   = 0;
    rst_a     = 1'b1;
    rst_b     = 1'b1;
    bus_a.req = 8'hFF;
    bus_b.req = 8'h00;

    // 1: reset holds grant off; first edge after release grants requester 0
    #2 chk_quiet_a("reset_held");
    step(1'b0, 8'hFF, 8'h00, 1'b0);
    step(1'b0, 8'hFF, 8'h01, 1'b0);
    rst_a = 1'b0;

    // 2: mandatory gap and wrap of the pointer past requester 7
    reset_a();
    step(1'b0, 8'h81, 8'h01, 1'b0);
    step(1'b0, 8'h80, 8'h00, 1'b0);
    step(1'b0, 8'h80, 8'h80, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 8'h03, 8'h01, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0);

    // 4: ptr=1 now; grant 04 ignores other req changes, then rotates to 08
    step(1'b0, 8'h04, 8'h04, 1'b0);
    step(1'b0, 8'hFF, 8'h04, 1'b0);
    step(1'b0, 8'h0F, 8'h04, 1'b0);
    step(1'b0, 8'hFF, 8'h04, 1'b0);
    step(1'b0, 8'hFB, 8'h00, 1'b0);
    step(1'b0, 8'hFF, 8'h08, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0);

    // 3: all requesting with MAX_HOLD=4: 4-cycle grants, timeout pulse in each gap
    reset_a();
    for (int i = 0; i < 9; i++) begin
      logic [7:0] one;
      one = 8'h01 << (i % 8);
      for (int k = 0; k < 4; k++) step(1'b0, 8'hFF, one, 1'b0);
      step(1'b0, 8'hFF, 8'h00, 1'b1);
    end
    step(1'b0, 8'h00, 8'h00, 1'b0);

    // 5: asynchronous reset mid-grant clears at once and restores ptr=0
    reset_a();
    step(1'b0, 8'h20, 8'h20, 1'b0);
    @(posedge clk);
    #3 rst_a = 1'b1;
    #1 chk_quiet_a("async_reset_mid_grant");
    step(1'b0, 8'h21, 8'h01, 1'b0);
    rst_a = 1'b0;
    step(1'b0, 8'h00, 8'h00, 1'b0);

    // 6: MAX_HOLD=3, drop on the timeout edge -> normal release, then a real timeout
    @(negedge clk);
    rst_b = 1'b0;
    step(1'b1, 8'h04, 8'h04, 1'b0);
    step(1'b1, 8'h04, 8'h04, 1'b0);
    step(1'b1, 8'h04, 8'h04, 1'b0);
    step(1'b1, 8'h00, 8'h00, 1'b0);
    step(1'b1, 8'h04, 8'h04, 1'b0);
    step(1'b1, 8'h04, 8'h04, 1'b0);
    step(1'b1, 8'h04, 8'h04, 1'b0);
    step(1'b1, 8'h04, 8'h00, 1'b1);
    step(1'b1, 8'h00, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
